// File: rtl/jpeg_zigzag_rle.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// jpeg_zigzag_rle : 8x8 coefficient buffer, zig-zag rescan, JPEG run-length symbols
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module jpeg_zigzag_rle (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_run,
  output logic [3:0] out_size,
  output logic [7:0] out_value,
  output logic       out_eob,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic [0:0] {FILL = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [7:0] mem [64];

  state_t     state, state_n;
  logic [5:0] wr_cnt, wr_cnt_n;
  logic [5:0] k, k_n;
  logic [5:0] run, run_n;
  logic       out_valid_n, out_eob_n, out_last_n;
  logic [3:0] out_run_n, out_size_n;
  logic [7:0] out_value_n;

  logic [7:0] coef;
  logic [3:0] coef_size;
  logic       accept, can_load;

  // Magnitude is formed in 9 bits so that -128 maps to size 8 without overflow.
  function automatic logic [3:0] size_of(input logic [7:0] v);
    logic [8:0] mag;
    mag     = v[7] ? (9'd0 - {v[7], v}) : {1'b0, v};
    size_of = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (mag[i]) size_of = 4'(i + 1);
    end
  endfunction

  assign in_ready  = (state == FILL);
  assign busy      = (state == SCAN);
  assign coef      = mem[ZZ[k]];
  assign coef_size = size_of(coef);
  assign accept    = out_valid && out_ready;
  assign can_load  = !out_valid || out_ready;

  always_ff @(posedge CLK_I) begin
    if (in_valid && in_ready) mem[wr_cnt] <= in_data;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= FILL;
      wr_cnt    <= 6'd0;
      k         <= 6'd0;
      run       <= 6'd0;
      out_valid <= 1'b0;
      out_run   <= 4'd0;
      out_size  <= 4'd0;
      out_value <= 8'd0;
      out_eob   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      wr_cnt    <= wr_cnt_n;
      k         <= k_n;
      run       <= run_n;
      out_valid <= out_valid_n;
      out_run   <= out_run_n;
      out_size  <= out_size_n;
      out_value <= out_value_n;
      out_eob   <= out_eob_n;
      out_last  <= out_last_n;
    end
  end

  always_comb begin
    state_n     = state;
    wr_cnt_n    = wr_cnt;
    k_n         = k;
    run_n       = run;
    out_valid_n = out_valid;
    out_run_n   = out_run;
    out_size_n  = out_size;
    out_value_n = out_value;
    out_eob_n   = out_eob;
    out_last_n  = out_last;

    case (state)
      FILL: begin
        if (in_valid) begin
          wr_cnt_n = wr_cnt + 6'd1;
          if (wr_cnt == 6'd63) begin
            state_n = SCAN;
            k_n     = 6'd0;
            run_n   = 6'd0;
          end
        end
      end

      SCAN: begin
        if (accept) begin
          out_valid_n = 1'b0;
          if (out_last) begin
            state_n    = FILL;
            wr_cnt_n   = 6'd0;
            out_last_n = 1'b0;
            out_eob_n  = 1'b0;
          end
        end
        // A pending final symbol blocks any further scanning of the block.
        if (can_load && !(out_valid && out_last)) begin
          if (k == 6'd0) begin
            out_valid_n = 1'b1;
            out_run_n   = 4'd0;
            out_size_n  = coef_size;
            out_value_n = coef;
            out_eob_n   = 1'b0;
            out_last_n  = 1'b0;
            k_n         = 6'd1;
          end else if (coef == 8'd0) begin
            if (k == 6'd63) begin
              out_valid_n = 1'b1;
              out_run_n   = 4'd0;
              out_size_n  = 4'd0;
              out_value_n = 8'd0;
              out_eob_n   = 1'b1;
              out_last_n  = 1'b1;
            end else begin
              run_n = run + 6'd1;
              k_n   = k + 6'd1;
            end
          end else if (run >= 6'd16) begin
            out_valid_n = 1'b1;
            out_run_n   = 4'd15;
            out_size_n  = 4'd0;
            out_value_n = 8'd0;
            out_eob_n   = 1'b0;
            out_last_n  = 1'b0;
            run_n       = run - 6'd16;
          end else begin
            out_valid_n = 1'b1;
            out_run_n   = run[3:0];
            out_size_n  = coef_size;
            out_value_n = coef;
            out_eob_n   = 1'b0;
            out_last_n  = (k == 6'd63);
            run_n       = 6'd0;
            k_n         = k + 6'd1;
          end
        end
      end

      default: state_n = FILL;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_zigzag_rle.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jpeg_zigzag_rle : directed bench for the zig-zag run-length stage
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_jpeg_zigzag_rle;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [3:0] out_run, out_size;
  logic [7:0] out_value;
  logic       out_eob, out_last, busy;
  logic [17:0] cur;

  int checks = 0;
  int fails  = 0;

  jpeg_zigzag_rle dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_size  (out_size),
    .out_value (out_value),
    .out_eob   (out_eob),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign cur = {out_eob, out_last, out_run, out_size, out_value};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] sym(input logic eob, input logic last,
                                      input logic [3:0] r, input logic [3:0] s,
                                      input logic [7:0] v);
    return {eob, last, r, s, v};
  endfunction

  // Called and returns at a falling edge; counts only handshakes seen at the edge.
  task automatic feed(input logic [7:0] b [64], input bit gaps);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < 64 && cyc < 1000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = b[idx];
      hs       = in_valid && in_ready;
      @(posedge clk);
      if (hs) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("feed_done", idx, 64);
    in_valid = 1'b0;
  endtask

  task automatic collect(input logic [17:0] exps [8], input int n, input int stop_after,
                         input bit rnd, input logic hv, input logic [7:0] hd);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit done = 1'b0;
    logic [17:0] held = '0;
    while (!done && cyc < 2000) begin
      in_valid  = hv;
      in_data   = hd;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) chk("stable_while_stalled", cur, held);
      chk("in_ready_during_scan", in_ready, 0);
      chk("busy_during_scan", busy, 1);
      stalled = out_valid && !out_ready;
      held    = cur;
      if (out_valid && out_ready) begin
        if (got < n) chk($sformatf("symbol_%0d", got), cur, exps[got]);
        else         chk("extra_symbol", got, n);
        got++;
        if (got == n || got == stop_after) done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("collect_timeout", done, 1);
    if (got == n) begin
      chk("in_ready_after_last", in_ready, 1);
      chk("busy_after_last", busy, 0);
      chk("out_valid_after_last", out_valid, 0);
    end
  endtask

  logic [7:0]  blk0 [64];
  logic [7:0]  blk2 [64];
  logic [7:0]  blk3 [64];
  logic [17:0] exp1 [8];
  logic [17:0] exp2 [8];
  logic [17:0] exp3 [8];

  initial begin
    for (int i = 0; i < 64; i++) begin
      blk0[i] = 8'd0;
      blk2[i] = 8'd0;
      blk3[i] = 8'd0;
    end
    blk2[0]  = 8'd6;
    blk2[7]  = 8'hFF;
    blk2[14] = 8'd4;
    blk3[63] = 8'h80;

    for (int i = 0; i < 8; i++) begin
      exp1[i] = '0;
      exp2[i] = '0;
      exp3[i] = '0;
    end
    exp1[0] = sym(1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
    exp1[1] = sym(1'b1, 1'b1, 4'd0, 4'd0, 8'd0);

    exp2[0] = sym(1'b0, 1'b0, 4'd0,  4'd3, 8'd6);
    exp2[1] = sym(1'b0, 1'b0, 4'd15, 4'd0, 8'd0);
    exp2[2] = sym(1'b0, 1'b0, 4'd11, 4'd1, 8'hFF);
    exp2[3] = sym(1'b0, 1'b0, 4'd0,  4'd3, 8'd4);
    exp2[4] = sym(1'b1, 1'b1, 4'd0,  4'd0, 8'd0);

    exp3[0] = sym(1'b0, 1'b0, 4'd0,  4'd0, 8'd0);
    exp3[1] = sym(1'b0, 1'b0, 4'd15, 4'd0, 8'd0);
    exp3[2] = sym(1'b0, 1'b0, 4'd15, 4'd0, 8'd0);
    exp3[3] = sym(1'b0, 1'b0, 4'd15, 4'd0, 8'd0);
    exp3[4] = sym(1'b0, 1'b1, 4'd14, 4'd8, 8'h80);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fields", cur, 0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero block, with the DC latency checked explicitly.
    feed(blk0, 1'b0);
    chk("scan_entry_busy", busy, 1);
    chk("scan_entry_in_ready", in_ready, 0);
    chk("dc_not_yet_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("dc_valid_after_e_plus_1", out_valid, 1);
    collect(exp1, 2, 2, 1'b0, 1'b0, 8'd0);

    feed(blk2, 1'b0);
    collect(exp2, 5, 5, 1'b0, 1'b0, 8'd0);

    feed(blk3, 1'b0);
    collect(exp3, 5, 5, 1'b0, 1'b0, 8'd0);

    // Same block as before, with input gaps and random backpressure.
    feed(blk2, 1'b1);
    collect(exp2, 5, 5, 1'b1, 1'b0, 8'd0);

    // Asynchronous reset mid-scan, then a clean all-zero block.
    feed(blk2, 1'b0);
    collect(exp2, 5, 3, 1'b0, 1'b0, 8'd0);
    #2 rst = 1'b1;
    #1;
    chk("midscan_reset_out_valid", out_valid, 0);
    chk("midscan_reset_in_ready", in_ready, 1);
    chk("midscan_reset_busy", busy, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    feed(blk0, 1'b0);
    collect(exp1, 2, 2, 1'b0, 1'b0, 8'd0);

    // Streaming: input valid stays high across the block boundary.
    feed(blk2, 1'b0);
    collect(exp2, 5, 5, 1'b0, 1'b1, blk3[0]);
    feed(blk3, 1'b0);
    collect(exp3, 5, 5, 1'b0, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
